// File: rtl/fxp_pkg.sv
// Qm.n fixed-point constants and the saturating two's-complement adder used by sat_add_arbiter.
// The default format is Q8.8; a design that imports this package must use the same total width.
package fxp_pkg;

  localparam int FXP_INT  = 8;
  localparam int FXP_FRAC = 8;
  localparam int FXP_W    = FXP_INT + FXP_FRAC;

  localparam logic [FXP_W-1:0] FXP_MAX = {1'b0, {(FXP_W-1){1'b1}}};
  localparam logic [FXP_W-1:0] FXP_MIN = {1'b1, {(FXP_W-1){1'b0}}};

  typedef logic [FXP_W-1:0] fxp_t;

  typedef struct packed {
    logic sat;
    fxp_t sum;
  } fxp_res_t;

  // Overflow is only possible when both operands share a sign and the wrapped sum flips it.
  function automatic fxp_res_t fxp_sat_add(input fxp_t a, input fxp_t b);
    fxp_t     s;
    fxp_res_t r;
    s     = a + b;
    r.sat = 1'b0;
    r.sum = s;
    if (!a[FXP_W-1] && !b[FXP_W-1] && s[FXP_W-1]) begin
      r.sat = 1'b1;
      r.sum = FXP_MAX;
    end else if (a[FXP_W-1] && b[FXP_W-1] && !s[FXP_W-1]) begin
      r.sat = 1'b1;
      r.sum = FXP_MIN;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_add_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr (wrapping) wins.
// Holds no state; the owning module keeps and advances the pointer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDW = $clog2(N);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/sat_add_arbiter.sv
// One saturating Qm.n adder shared round-robin by NREQ valid/ready requesters, 2-stage pipeline.
// Optional saturation-event counter (sat_cnt/sat_clr) is built when SAT_ADD_ARB_SAT_CNT_EN is defined.
module sat_add_arbiter
  import fxp_pkg::*;
#(
  parameter int INT  = FXP_INT,
  parameter int FRAC = FXP_FRAC,
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*(INT+FRAC)-1:0] req_a,
  input  logic [NREQ*(INT+FRAC)-1:0] req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [INT+FRAC-1:0]       res_data,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic                      res_sat,
  output logic                      busy
`ifdef SAT_ADD_ARB_SAT_CNT_EN
  ,
  output logic [15:0]               sat_cnt,
  input  logic                      sat_clr
`endif
);

  localparam int W   = INT + FRAC;
  localparam int IDW = $clog2(NREQ);

  logic [W-1:0]    lane_a [NREQ];
  logic [W-1:0]    lane_b [NREQ];

  logic            a_valid_q;
  logic [W-1:0]    a_a_q, a_b_q;
  logic [IDW-1:0]  a_id_q;
  logic            b_valid_q;
  logic [W-1:0]    b_data_q;
  logic [IDW-1:0]  b_id_q;
  logic            b_sat_q;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic            b_adv, a_adv, accept;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  fxp_res_t        add_res;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign lane_a[gi] = req_a[gi*W +: W];
    assign lane_b[gi] = req_b[gi*W +: W];
  end

  // Stage B drains on res_ready; stage A may only refill when it is empty or B moves.
  assign b_adv  = !b_valid_q || res_ready;
  assign a_adv  = !a_valid_q || b_adv;
  assign accept = |gnt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (a_adv),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are masked while reset is held so no requester sees a handshake that is then dropped.
  assign req_ready = rst ? '0 : gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign add_res = fxp_sat_add(a_a_q, a_b_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_a_q     <= '0;
      a_b_q     <= '0;
      a_id_q    <= '0;
      ptr_q     <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (a_adv) begin
        a_valid_q <= accept;
      end
      if (accept) begin
        a_a_q  <= lane_a[gnt_idx];
        a_b_q  <= lane_b[gnt_idx];
        a_id_q <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_id_q    <= '0;
      b_sat_q   <= 1'b0;
    end else if (b_adv) begin
      b_valid_q <= a_valid_q;
      if (a_valid_q) begin
        b_data_q <= add_res.sum;
        b_sat_q  <= add_res.sat;
        b_id_q   <= a_id_q;
      end
    end
  end

  assign res_valid = b_valid_q;
  assign res_data  = b_data_q;
  assign res_id    = b_id_q;
  assign res_sat   = b_sat_q;
  assign busy      = a_valid_q || b_valid_q;

`ifdef SAT_ADD_ARB_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Clear has priority over a coincident increment; the count sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (b_valid_q && res_ready && b_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule
